// File: rtl/amp_i2c_target.sv
// I2C target for the amplifier front end: oversampled SCL/SDA, 7-bit address match,
// 8-bit register pointer with auto-increment, single-cycle register-file port.
module amp_i2c_target #(
    parameter logic [6:0] I2C_ADDR    = 7'b0100000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic                   oe_q, oe_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;

    logic scl, sda, scl_rise, scl_fall, start, stop;

    // Synchronizers reset to 1 so an idle bus produces no spurious events.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl      = scl_sync_q[SYNC_STAGES-1];
    assign sda      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            wr_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        oe_d      = oe_q;
        busy_d    = busy_q;
        ack_d     = ack_q;

        // STOP outranks everything, including a coincident SCL rise.
        if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == I2C_ADDR) begin
                            state_d = ADDR_ACK;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b0;
                        if (shift_q[0]) begin
                            state_d = RDATA;
                            shift_d = reg_rdata;
                            oe_d    = ~reg_rdata[7];
                        end else begin
                            state_d = PTR;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        addr_d  = shift_q;
                        state_d = PTR_ACK;
                        oe_d    = 1'b1;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (state_q == WDATA_ACK) addr_d = addr_q + 8'd1;
                        state_d   = WDATA;
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b0;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Strobe only once the byte is complete; a STOP mid-byte never writes.
                        if (bit_cnt_q == 4'd7) begin
                            wdata_d = {shift_q[6:0], sda};
                            wr_d    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = WDATA_ACK;
                        oe_d    = 1'b1;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d = RDATA_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    // Pointer moves at the ACK sample so reg_rdata settles before the reload.
                    if (scl_rise) begin
                        ack_d = ~sda;
                        if (!sda) addr_d = addr_q + 8'd1;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            state_d   = RDATA;
                            bit_cnt_d = 4'd0;
                            shift_d   = reg_rdata;
                            oe_d      = ~reg_rdata[7];
                        end else begin
                            state_d = IGNORE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                IGNORE:  oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign sda_oe    = oe_q;
    assign reg_wr    = wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_amp_i2c_target.sv
// Directed bench for amp_i2c_target: bit-banged I2C master, open-drain bus model,
// scoreboards for register writes and read-back bytes.
`timescale 1ns/1ps
module tb_amp_i2c_target;

    logic       clk = 1'b0;
    logic       resetb;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic       sda_oe, reg_wr, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic [7:0] regs [0:255];

    int ncmp = 0;
    int nerr = 0;
    int wr_seen = 0;
    logic       oe_seen;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    always #5 clk = ~clk;

    assign sda_bus   = m_sda & ~sda_oe;
    assign reg_rdata = regs[reg_addr];

    amp_i2c_target #(.I2C_ADDR(7'b0100000), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .scl_in    (m_scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard: every strobe must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (resetb && reg_wr) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                check("unexpected_wr", {15'd0, reg_wr}, 16'd0);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr_data", {reg_addr, reg_wdata}, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit tasks begin and end just after SCL falls; SCL period = 32 clk.
    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            tick(8); m_sda = 1'b1;
            tick(8); m_scl = 1'b1;
        end
        tick(8); m_sda = 1'b0;
        tick(8); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(8);  m_sda = 1'b0;
        tick(8);  m_scl = 1'b1;
        tick(8);  m_sda = 1'b1;
        tick(16);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        tick(8); m_sda = b;
        tick(8); m_scl = 1'b1;
        tick(8); s = sda_bus;
        tick(8); m_scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(~mack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         wr_before;

        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h40] = 8'h18;
        regs[8'h41] = 8'hA5;

        resetb = 1'b0; m_scl = 1'b1; m_sda = 1'b1; oe_seen = 1'b0;
        tick(3);
        check("rst_sda_oe",    {15'd0, sda_oe}, 16'd0);
        check("rst_reg_wr",    {15'd0, reg_wr}, 16'd0);
        check("rst_reg_addr",  {8'd0, reg_addr}, 16'h0000);
        check("rst_reg_wdata", {8'd0, reg_wdata}, 16'h0000);
        check("rst_busy",      {15'd0, busy}, 16'd0);
        resetb = 1'b1;
        tick(5);

        // Wrong address: no ACK anywhere, no write, pointer untouched.
        oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'h42, ack); check("wa_addr_nack", {15'd0, ack}, 16'd0);
        wr_byte(8'h10, ack);
        wr_byte(8'h55, ack);
        i2c_stop();
        check("wa_oe_never", {15'd0, oe_seen}, 16'd0);
        check("wa_no_wr",    16'(wr_seen), 16'd0);
        check("wa_reg_addr", {8'd0, reg_addr}, 16'h0000);

        // Single write 0x35 <- 0x08.
        i2c_start();
        tick(1); check("wr_busy_set", {15'd0, busy}, 16'd1);
        exp_wr.push_back({8'h35, 8'h08});
        wr_byte(8'h40, ack); check("wr_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h35, ack); check("wr_ack_ptr",  {15'd0, ack}, 16'd1);
        wr_byte(8'h08, ack); check("wr_ack_data", {15'd0, ack}, 16'd1);
        i2c_stop();
        check("wr_busy_clr", {15'd0, busy}, 16'd0);
        check("wr_count",    16'(wr_seen), 16'd1);
        check("wr_sb_empty", 16'(exp_wr.size()), 16'd0);

        // Burst across the pointer wrap.
        i2c_start();
        wr_byte(8'h40, ack);
        wr_byte(8'hFE, ack);
        exp_wr.push_back({8'hFE, 8'h11});
        wr_byte(8'h11, ack); check("bw_ack0", {15'd0, ack}, 16'd1);
        exp_wr.push_back({8'hFF, 8'h22});
        wr_byte(8'h22, ack); check("bw_ack1", {15'd0, ack}, 16'd1);
        exp_wr.push_back({8'h00, 8'h33});
        wr_byte(8'h33, ack); check("bw_ack2", {15'd0, ack}, 16'd1);
        i2c_stop();
        check("bw_sb_empty", 16'(exp_wr.size()), 16'd0);
        check("bw_addr_after", {8'd0, reg_addr}, 16'h0001);

        // Pointer write, repeated START, two-byte read (ACK then NACK).
        i2c_start();
        wr_byte(8'h40, ack);
        wr_byte(8'h40, ack); check("rd_ack_ptr", {15'd0, ack}, 16'd1);
        i2c_start();
        wr_byte(8'h41, ack); check("rd_ack_addr", {15'd0, ack}, 16'd1);
        exp_rd.push_back(regs[8'h40]);
        exp_rd.push_back(regs[8'h41]);
        rd_byte(1'b1, d); check("rd_byte0", {8'd0, d}, {8'd0, exp_rd.pop_front()});
        rd_byte(1'b0, d); check("rd_byte1", {8'd0, d}, {8'd0, exp_rd.pop_front()});
        tick(8);
        check("rd_oe_released", {15'd0, sda_oe}, 16'd0);
        check("rd_busy_ignore", {15'd0, busy}, 16'd1);
        bit_xfer(1'b0, s);
        check("rd_ignore_no_ack", {15'd0, sda_oe}, 16'd0);
        i2c_stop();
        check("rd_busy_clr", {15'd0, busy}, 16'd0);
        check("rd_no_wr", 16'(exp_wr.size()), 16'd0);

        // Abort after four data bits, then a normal write.
        wr_before = wr_seen;
        i2c_start();
        wr_byte(8'h40, ack);
        wr_byte(8'h50, ack);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
        i2c_stop();
        check("ab_no_wr", 16'(wr_seen), 16'(wr_before));
        check("ab_busy",  {15'd0, busy}, 16'd0);
        i2c_start();
        exp_wr.push_back({8'h10, 8'h77});
        wr_byte(8'h40, ack); check("ab_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h10, ack);
        wr_byte(8'h77, ack); check("ab_ack_data", {15'd0, ack}, 16'd1);
        i2c_stop();
        check("ab_wr_done", 16'(wr_seen), 16'(wr_before + 1));

        // Asynchronous reset while the target drives the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(i == 6, s);
        tick(8);
        check("rs_pre_oe", {15'd0, sda_oe}, 16'd1);
        #2 resetb = 1'b0;
        #1;
        check("rs_sda_oe",   {15'd0, sda_oe}, 16'd0);
        check("rs_busy",     {15'd0, busy}, 16'd0);
        check("rs_reg_addr", {8'd0, reg_addr}, 16'h0000);
        check("rs_reg_wdata",{8'd0, reg_wdata}, 16'h0000);
        check("rs_reg_wr",   {15'd0, reg_wr}, 16'd0);
        tick(2); m_scl = 1'b1; m_sda = 1'b1;
        tick(4); resetb = 1'b1;
        tick(8);
        check("rs_idle_busy", {15'd0, busy}, 16'd0);
        check("final_sb_empty", 16'(exp_wr.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
